vending_controller: RTL

Parametrised multi-product vending controller and the successor to the single-price coin FSM. Accumulates credit from coded coins with an overflow guard. Vends one of NUM_PROD products when credit covers PRICE and stock remains, then returns change one unit-coin per cycle. Cancel refunds the full credit. Sits between the coin acceptor and the dispenser/change hopper drivers.

---
 rtl/vending_pkg.sv | 11 +
 rtl/vending_controller_stock.sv | 36 +++
 rtl/vending_controller.sv | 103 ++++++++++
 3 files changed

// File: rtl/vending_pkg.sv
// vending_pkg: coin codes, coin-to-unit conversion and controller state encoding.
package vending_pkg;
  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_4    = 2'b11;
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_CHANGE} state_t;
  function automatic logic [2:0] coin_value(input logic [1:0] code);
    return code == COIN_4 ? 3'd4 : {1'b0, code};
  endfunction
endpackage

// File: rtl/vending_controller_stock.sv
// vend_stock_bank: per-product stock counters with indexed decrement, restock and sold_out flags.
module vend_stock_bank #(
  parameter int NUM_PROD = 4,
  parameter int STOCK_INIT = 8,
  localparam int SEL_W = $clog2(NUM_PROD),
  localparam int STOCK_W = $clog2(STOCK_INIT + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec,
  input  logic [SEL_W-1:0]    dec_idx,
  input  logic                restock,
  output logic [NUM_PROD-1:0] sold_out
);
  logic [STOCK_W-1:0] stock_q [NUM_PROD];
  logic [STOCK_W-1:0] stock_d [NUM_PROD];
  logic [NUM_PROD-1:0] sold_out_q, sold_out_d;
  // sold_out is registered from the next stock value so it moves together with dispense
  always_comb begin
    for (int i = 0; i < NUM_PROD; i++) begin
      stock_d[i] = restock ? STOCK_W'(STOCK_INIT)
                 : stock_q[i] - STOCK_W'(dec && 32'(dec_idx) == i && stock_q[i] != '0);
      sold_out_d[i] = stock_d[i] == '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      sold_out_q <= '0;
    end else begin
      stock_q <= stock_d;
      sold_out_q <= sold_out_d;
    end
  end
  assign sold_out = sold_out_q;
endmodule

// File: rtl/vending_controller.sv
// vending_controller: multi-product vending FSM with guarded credit, stock tracking and unit change return.
module vending_controller
  import vending_pkg::*;
#(
  parameter int PRICE = 3,
  parameter int MAX_CREDIT = 15,
  parameter int NUM_PROD = 4,
  parameter int STOCK_INIT = 8,
  localparam int CREDIT_W = $clog2(MAX_CREDIT + 1),
  localparam int SEL_W = $clog2(NUM_PROD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                restock,
  output logic                dispense,
  output logic [SEL_W-1:0]    dispense_id,
  output logic                change_coin,
  output logic                coin_reject,
  output logic                sel_err,
  output logic [CREDIT_W-1:0] credit,
  output logic [NUM_PROD-1:0] sold_out,
  output logic                busy
);
  state_t state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0] dispense_id_q, dispense_id_d;
  logic dispense_q, dispense_d, change_coin_q, change_coin_d;
  logic coin_reject_q, coin_reject_d, sel_err_q, sel_err_d, busy_q, busy_d;
  logic accepting, coin_in, cancel_ok, sel_ok, coin_ok;

  vend_stock_bank #(.NUM_PROD(NUM_PROD), .STOCK_INIT(STOCK_INIT)) u_stock (
    .clk(clk), .rst_n(rst_n), .dec(sel_ok), .dec_idx(sel),
    .restock(restock && state_q == S_IDLE), .sold_out(sold_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      credit_q <= '0;
      dispense_id_q <= '0;
      dispense_q <= 1'b0;
      change_coin_q <= 1'b0;
      coin_reject_q <= 1'b0;
      sel_err_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      dispense_id_q <= dispense_id_d;
      dispense_q <= dispense_d;
      change_coin_q <= change_coin_d;
      coin_reject_q <= coin_reject_d;
      sel_err_q <= sel_err_d;
      busy_q <= busy_d;
    end
  end

  // Priority: cancel beats sel_valid beats coin; the credit is reduced as soon as a sale is accepted
  always_comb begin
    accepting = state_q == S_IDLE || state_q == S_COLLECT;
    coin_in = coin != COIN_NONE;
    cancel_ok = cancel && state_q == S_COLLECT;
    sel_ok = sel_valid && !cancel_ok && state_q == S_COLLECT && credit_q >= CREDIT_W'(PRICE)
             && 32'(sel) < NUM_PROD && !sold_out[sel];
    coin_ok = coin_in && accepting && !cancel_ok && !sel_valid
              && 32'(credit_q) + 32'(coin_value(coin)) <= 32'(MAX_CREDIT);
    state_d = state_q;
    credit_d = credit_q;
    if (cancel_ok) state_d = S_CHANGE;
    else if (sel_ok) begin
      state_d = S_VEND;
      credit_d = credit_q - CREDIT_W'(PRICE);
    end else if (coin_ok) begin
      state_d = S_COLLECT;
      credit_d = credit_q + CREDIT_W'(coin_value(coin));
    end else if (state_q == S_VEND) state_d = credit_q == '0 ? S_IDLE : S_CHANGE;
    else if (state_q == S_CHANGE) begin
      credit_d = credit_q - 1'b1;
      state_d = credit_q == CREDIT_W'(1) ? S_IDLE : S_CHANGE;
    end
  end

  always_comb begin
    dispense_d = state_d == S_VEND;
    change_coin_d = state_d == S_CHANGE;
    busy_d = dispense_d || change_coin_d;
    coin_reject_d = coin_in && !coin_ok;
    sel_err_d = sel_valid && !sel_ok;
    dispense_id_d = sel_ok ? sel : dispense_id_q;
  end

  assign dispense = dispense_q;
  assign dispense_id = dispense_id_q;
  assign change_coin = change_coin_q;
  assign coin_reject = coin_reject_q;
  assign sel_err = sel_err_q;
  assign credit = credit_q;
  assign busy = busy_q;
endmodule
